// File: rtl/output_port.sv
// Output port buffer: circular FIFO between the processor control unit and a
// ready/valid consumer, with a sticky overflow flag for dropped writes.
module output_port #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       output_enable,
    input  logic [DATA_WIDTH-1:0]      output_data,
    input  logic                       out_ready,
    input  logic                       clear_overflow,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;

    logic push;
    logic pop;
    logic push_ok;
    logic drop;

    // Accept/drop decisions; a pop frees the slot a full-buffer push needs.
    always_comb begin
        push    = output_enable;
        pop     = out_valid && out_ready;
        push_ok = push && (!fifo_full || pop);
        drop    = push && fifo_full && !pop;
    end

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (reset && push_ok) begin
            mem[wr_ptr] <= output_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - CNT_W'(1);
            end
            // Set wins over clear when both happen on the same edge.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clear_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    always_comb begin
        count      = count_q;
        overflow   = overflow_q;
        fifo_full  = (count_q == CNT_W'(DEPTH));
        fifo_empty = (count_q == '0);
        out_valid  = !fifo_empty;
        out_data   = mem[rd_ptr];
    end

endmodule

// File: doc/output_port.md
OUTPUT_PORT -- requirements
Module: output_port

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of every data path.
REQ-002 SHALL have parameter DEPTH, default 4, a power of two ≥2: number of buffer entries.
REQ-003 SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port output_enable  input  1  write strobe from the processor control unit; one entry per cycle while high.
REQ-006 SHALL have port output_data  input  DATA_WIDTH  value to capture.
REQ-007 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-008 SHALL have port clear_overflow  input  1  clears the sticky overflow flag.
REQ-009 SHALL have port out_valid  output  1  head entry is present.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  head entry value.
REQ-011 SHALL have port fifo_full  output  1  count equals DEPTH.
REQ-012 SHALL have port fifo_empty  output  1  count equals 0.
REQ-013 SHALL have port count  output  log2(DEPTH)+1  number of stored entries.
REQ-014 SHALL have port overflow  output  1  sticky; at least one write was dropped.

Function
REQ-015 SHALL be a circular buffer: read pointer, write pointer, each log2(DEPTH) bits, both wrapping from DEPTH-1 to 0.
REQ-016 SHALL define push = output_enable in a given cycle; pop = out_valid AND out_ready.
REQ-017 SHALL store output_data at the write pointer and advance it on push when not full, or when full and pop occurs in the same cycle.
REQ-018 SHALL drop the push when full and no pop occurs, and set overflow to 1 on that edge; storage, pointers and count SHALL be unchanged.
REQ-019 SHALL advance the read pointer on pop; pop while empty SHALL be impossible because out_valid is 0.
REQ-020 SHALL update count as +1 on push-only, -1 on pop-only, unchanged on simultaneous accepted push and pop, or on no accepted operation.
REQ-021 SHALL accept push and pop in the same cycle when empty only as push: data written while empty becomes visible on out_valid in the following cycle (1-cycle write-to-valid latency).
REQ-022 SHALL drive out_valid = NOT fifo_empty and out_data = entry at read pointer, combinationally from registered state.
REQ-023 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL clear overflow on a clk edge with clear_overflow=1; if a drop and clear_overflow occur in the same cycle, overflow SHALL be 1 (set wins).
REQ-025 SHALL derive fifo_full and fifo_empty from count, never from pointer equality alone.
REQ-026 SHALL preserve FIFO order exactly; no entry SHALL be duplicated or skipped across pointer wrap-around.

Reset
REQ-027 SHALL, while reset=0, asynchronously force pointers=0, count=0, overflow=0, so out_valid=0, fifo_empty=1, fifo_full=0.
REQ-028 SHALL discard all buffered entries on reset assertion mid-operation; storage contents need not be cleared.
REQ-029 SHALL ignore output_enable and out_ready while reset=0; first accepted push SHALL be on the first rising edge with reset=1.

Verification
REQ-030 Reset then output_enable=1 one cycle with output_data=0x5A, out_ready=0 -> next cycle out_valid=1, out_data=0x5A, count=1; out_ready=1 one cycle -> out_valid=0, count=0.
REQ-031 DEPTH=4, push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles, out_ready=0 -> fifo_full=1, count=4, overflow=1; drain yields 0x01..0x04 in order, 0x05 absent.
REQ-032 Full buffer, push 0x77 with out_ready=1 same cycle -> count stays 4, overflow stays 0, 0x77 emerges after the other three entries.
REQ-033 Stream 10 values with out_ready=1 continuously -> all 10 emerge in order, count never exceeds 1, pointers wrap twice without loss.
REQ-034 overflow=1, clear_overflow=1 with drop-causing push same cycle -> overflow remains 1; clear_overflow=1 next cycle without push -> overflow=0.
REQ-035 Three entries stored, reset pulsed low between clock edges -> out_valid=0, count=0 immediately, before the next clk edge.
